muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit: the sequential successor to the combinational N-bit adder/ALU-mux datapath.
- Implements the full RISC-V M-extension operation set for an N-bit datapath, one radix-2 step per clock.
- Sits beside the ALU in the EX stage. The pipeline stalls on in_ready/out_valid and may kill an operation with flush.

Parameters:
N, 32, operand/result width in bits (N >= 4).
CNT_W, $clog2(N)+1, iteration counter width.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of any in-flight operation
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  N  rs1 operand
b  input  N  rs2 operand
out_valid  output  1  result available
out_ready  input  1  consumer takes result
result  output  N  operation result
div_by_zero  output  1  DIV/DIVU/REM/REMU with b == 0 (qualified by out_valid)
div_overflow  output  1  DIV/REM with a = most-negative and b = all-ones (qualified by out_valid)

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: clk, rst_n.
- Reset state: state=IDLE; in_ready=1; out_valid=0; result=0; div_by_zero=0; div_overflow=0; counter and internal registers = 0.
- FSM states: IDLE, CALC, FIX, DONE.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- Priority on every edge: rst_n low > flush > normal operation.
- flush=1 forces IDLE on the next edge and clears out_valid and both flags, from any state. A request presented in the same cycle as flush is dropped.
- IDLE, on in_valid=1:
  - Latch op and the operand signs.
  - Load |a| and |b|. Signedness follows op: MULH both operands signed; MULHSU a signed, b unsigned; DIV/REM signed; others unsigned. MUL low word is sign-agnostic and uses unsigned magnitudes.
  - Set counter = N.
  - Next state is CALC, or DONE for the special cases below.
- Special cases (resolved at acceptance; out_valid is high in the cycle after acceptance):
  - Divide op with b == 0: DIV/DIVU result = all-ones; REM/REMU result = a; div_by_zero = 1.
  - DIV/REM with a = 1 followed by N-1 zeros and b = all-ones: DIV result = a; REM result = 0; div_overflow = 1.
- CALC: one step per edge, counter decrements; on counter == 1 the next state is FIX.
  - Multiply: shift-add into a 2N-bit accumulator.
  - Divide: restoring shift-subtract on an N-bit remainder and quotient.
- FIX (one cycle): apply sign correction, register result, next state DONE.
  - Product is negated if the operand signs differ (signed ops only).
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Result selection: MUL = product[N-1:0]; MULH/MULHSU/MULHU = product[2N-1:N]; DIV/DIVU = quotient; REM/REMU = remainder.
- Latency, normal path: acceptance edge, then N CALC edges, then the FIX edge. out_valid is first high N+2 cycles after the acceptance cycle (34 for N=32).
- DONE:
  - result, div_by_zero and div_overflow are held stable while out_ready=0.
  - On out_valid && out_ready: next state IDLE, out_valid drops, in_ready rises the next cycle.
  - No same-cycle acceptance of a new request while in DONE.
- Operand inputs a, b and op are don't-care outside the acceptance cycle.
- All arithmetic is modulo 2^N or 2^2N. There is no exception output beyond the two flags.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), out_ready=1 -> result 0xFFFFFFEB, out_valid rises exactly 34 cycles after the acceptance cycle, in_ready=0 throughout.
- MULH a=b=0x80000000 -> 0x40000000. MULHU with the same operands -> 0x40000000. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU a=5, b=0 -> result 0xFFFFFFFF, div_by_zero=1, out_valid one cycle after acceptance. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, div_overflow=1. REM with the same operands -> 0.
- Hold out_ready=0 for 10 cycles in DONE -> result and flags stable, in_ready=0. Assert out_ready -> IDLE next cycle, in_ready=1.
- Assert flush at CALC iteration 10 -> IDLE next edge, out_valid never rises; the following MUL 3*4 -> 12. Pulse rst_n low mid-CALC -> all outputs immediately at their reset values.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit covering the RISC-V M
// operation set. One shift-add (multiply) or restoring shift-subtract (divide)
// step per clock on operand magnitudes, with sign correction in a final cycle.
module muldiv_unit #(
  parameter int N     = 32,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         div_by_zero,
  output logic         div_overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  // Two's-complement negate when requested.
  function automatic logic [N-1:0] cond_neg(input logic [N-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*N-1:0] cond_neg2(input logic [2*N-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             neg_res_q, neg_res_d;   // operand signs differ
  logic             neg_a_q, neg_a_d;       // dividend was negative
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]   acc_q, acc_d;           // mul: {partial, multiplier}; div: {rem, quotient}
  logic [N-1:0]     opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [N-1:0]     result_q, result_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [N-1:0]     a_mag, b_mag;
  logic [N:0]       mul_sum;
  logic [N:0]       div_diff;
  logic [2*N-1:0]   prod;
  logic [N-1:0]     quo, rem;

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign result       = result_q;
  assign div_by_zero  = dbz_q;
  assign div_overflow = ovf_q;

  // Operand signedness by funct3 and magnitude extraction at acceptance.
  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed && a[N-1];
    b_neg    = b_signed && b[N-1];
    a_mag    = cond_neg(a, a_neg);
    b_mag    = cond_neg(b, b_neg);
  end

  // Next-state, datapath step and result selection.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;

    mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
    div_diff = acc_q[2*N-1:N-1] - {1'b0, opnd_q};
    prod     = cond_neg2(acc_q, neg_res_q);
    quo      = cond_neg(acc_q[N-1:0], neg_res_q);
    rem      = cond_neg(acc_q[2*N-1:N], neg_a_q);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d      = op;
          neg_res_d = a_neg ^ b_neg;
          neg_a_d   = a_neg;
          cnt_d     = CNT_W'(N);
          acc_d     = {{N{1'b0}}, a_mag};
          opnd_d    = b_mag;
          dbz_d     = 1'b0;
          ovf_d     = 1'b0;
          if (op[2] && (b == '0)) begin
            dbz_d    = 1'b1;
            result_d = op[1] ? a : {N{1'b1}};
            state_d  = S_DONE;
          end else if (op[2] && !op[0] && (a == MOST_NEG) && (b == {N{1'b1}})) begin
            ovf_d    = 1'b1;
            result_d = op[1] ? {N{1'b0}} : a;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q[2]) begin
          if (!div_diff[N]) acc_d = {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
          else              acc_d = {acc_q[2*N-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[N-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q[2])               result_d = op_q[1] ? rem : quo;
        else if (op_q[1:0] == 2'b00) result_d = prod[N-1:0];
        else                       result_d = prod[2*N-1:N];
        state_d = S_DONE;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase

    // A kill returns to idle, drops the result flags and ignores any request.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
      dbz_d    = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected responses are queued at issue
// time from an arithmetic reference model and popped by an output monitor.
module tb_muldiv_unit;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = '0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  result;
  logic          div_by_zero;
  logic          div_overflow;

  int n_vec = 0;
  int n_err = 0;
  bit rand_rdy = 1'b0;
  logic [33:0] exp_q[$];

  muldiv_unit #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_by_zero(div_by_zero), .div_overflow(div_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: {div_by_zero, div_overflow, result} from plain integer arithmetic.
  function automatic logic [33:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, uy_s;
    logic [63:0] ux, uy, p;
    logic [31:0] r;
    logic z, v;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    uy_s = uy;
    z = 1'b0;
    v = 1'b0;
    r = '0;
    case (o)
      3'd0: begin p = ux * uy;   r = p[31:0];  end
      3'd1: begin p = sx * sy;   r = p[63:32]; end
      3'd2: begin p = sx * uy_s; r = p[63:32]; end
      3'd3: begin p = ux * uy;   r = p[63:32]; end
      3'd4, 3'd6: begin
        if (y == 0) begin
          z = 1'b1;
          r = (o == 3'd4) ? 32'hFFFF_FFFF : x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          v = 1'b1;
          r = (o == 3'd4) ? x : 32'h0;
        end else begin
          r = (o == 3'd4) ? ($signed(x) / $signed(y)) : ($signed(x) % $signed(y));
        end
      end
      default: begin
        if (y == 0) begin
          z = 1'b1;
          r = (o == 3'd5) ? 32'hFFFF_FFFF : x;
        end else begin
          r = (o == 3'd5) ? (x / y) : (x % y);
        end
      end
    endcase
    return {z, v, r};
  endfunction

  // Output monitor: every handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {31'b0, out_valid, result}, 64'h0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("result", {32'b0, result}, {32'b0, e[31:0]});
        chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, e[33]});
        chk("div_overflow", {63'b0, div_overflow}, {63'b0, e[32]});
      end
    end
  end

  // Issue one request once the unit is idle; returns one cycle after acceptance.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    int guard;
    guard = 0;
    while (!in_ready && guard < 300) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("issue_timeout", 64'h0, 64'h1);
    op = o; a = x; b = y; in_valid = 1'b1;
    if (push) exp_q.push_back(ref_model(o, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || !in_ready) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k;
    // Reset state
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'h1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
    chk("rst_result", {32'b0, result}, 64'h0);
    chk("rst_flags", {62'b0, div_by_zero, div_overflow}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // MUL 7 * -3 with latency and in_ready tracking
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    k = 1;
    while (!out_valid && k < 100) begin
      chk("busy_in_ready", {63'b0, in_ready}, 64'h0);
      @(posedge clk); #1;
      k++;
    end
    chk("mul_latency", 64'(k), 64'd34);
    drain();

    // Directed operation table
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    do_op(3'd3, 32'h8000_0000, 32'h8000_0000, 1'b1);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op(3'd5, 32'd100, 32'd7, 1'b1);
    do_op(3'd7, 32'd100, 32'd7, 1'b1);
    drain();

    // Divide by zero resolves in one cycle
    do_op(3'd5, 32'd5, 32'd0, 1'b1);
    chk("dbz_latency", {63'b0, out_valid}, 64'h1);
    chk("dbz_value", {31'b0, div_by_zero, result}, {31'b0, 1'b1, 32'hFFFF_FFFF});
    drain();
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("ovf_latency", {63'b0, out_valid}, 64'h1);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op(3'd6, 32'd9, 32'd0, 1'b1);
    drain();

    // Hold result while the consumer stalls
    out_ready = 1'b0;
    do_op(3'd5, 32'd100, 32'd7, 1'b1);
    k = 0;
    while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
    repeat (10) begin
      chk("hold_valid", {63'b0, out_valid}, 64'h1);
      chk("hold_result", {32'b0, result}, 64'd14);
      chk("hold_in_ready", {63'b0, in_ready}, 64'h0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {63'b0, in_ready}, 64'h1);
    chk("release_out_valid", {63'b0, out_valid}, 64'h0);

    // Request coinciding with flush is dropped
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_ready", {63'b0, in_ready}, 64'h1);

    // Flush during CALC
    do_op(3'd0, 32'd123, 32'd456, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", {63'b0, in_ready}, 64'h1);
    k = 0;
    repeat (40) begin
      if (out_valid) k++;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", 64'(k), 64'h0);
    do_op(3'd0, 32'd3, 32'd4, 1'b1);
    drain();

    // Asynchronous reset mid-CALC
    do_op(3'd4, 32'd1000, 32'd3, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {63'b0, in_ready}, 64'h1);
    chk("arst_out_valid", {63'b0, out_valid}, 64'h0);
    chk("arst_result", {32'b0, result}, 64'h0);
    chk("arst_flags", {62'b0, div_by_zero, div_overflow}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
    drain();

    // Randomized operations with random consumer back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b1);
    end
    rand_rdy = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
